// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encoding, light codes and phase order for the traffic light controller
package traffic_pkg;

  localparam int REMAIN_W = 7;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED2   = 3'd5
  } state_e;

  function automatic state_e next_phase(input state_e s);
    case (s)
      MAIN_G:  next_phase = MAIN_Y;
      MAIN_Y:  next_phase = RED1;
      RED1:    next_phase = SIDE_G;
      SIDE_G:  next_phase = SIDE_Y;
      SIDE_Y:  next_phase = RED2;
      default: next_phase = MAIN_G;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick_sync.sv
// rtl/sec_tick_sync.sv - brings the seconds level into clk_20 and emits one pulse per rising edge
module sec_tick_sync (
  input  logic clk_20,
  input  logic rst,
  input  logic clk_1Hz,
  output logic sec_tick
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = clk_1Hz;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_20) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // s3 only records history; edge decision is made on the second sync stage
  assign sec_tick = s2_q & ~s3_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - timed main/side road light sequencer; SIDE_SENSOR_EN adds side_car gating
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned T_MAIN_GREEN  = 30,
  parameter int unsigned T_MAIN_YELLOW = 3,
  parameter int unsigned T_SIDE_GREEN  = 20,
  parameter int unsigned T_SIDE_YELLOW = 3,
  parameter int unsigned T_ALL_RED     = 1
) (
  input  logic                clk_20,
  input  logic                rst,
  input  logic                clk_1Hz,
`ifdef SIDE_SENSOR_EN
  input  logic                side_car,
`endif
  output logic [2:0]          main_light,
  output logic [2:0]          side_light,
  output logic [REMAIN_W-1:0] remain,
  output logic                sec_tick
);

  if (T_MAIN_GREEN  < 1 || T_MAIN_GREEN  > 127 ||
      T_MAIN_YELLOW < 1 || T_MAIN_YELLOW > 127 ||
      T_SIDE_GREEN  < 1 || T_SIDE_GREEN  > 127 ||
      T_SIDE_YELLOW < 1 || T_SIDE_YELLOW > 127 ||
      T_ALL_RED     < 1 || T_ALL_RED     > 127) begin : g_bad_duration
    $error("traffic_light_fsm: every phase duration must be in 1..127");
  end

  function automatic logic [REMAIN_W-1:0] dur_of(input state_e s);
    case (s)
      MAIN_G:  dur_of = REMAIN_W'(T_MAIN_GREEN);
      MAIN_Y:  dur_of = REMAIN_W'(T_MAIN_YELLOW);
      SIDE_G:  dur_of = REMAIN_W'(T_SIDE_GREEN);
      SIDE_Y:  dur_of = REMAIN_W'(T_SIDE_YELLOW);
      default: dur_of = REMAIN_W'(T_ALL_RED);
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [REMAIN_W-1:0] remain_q, remain_d;
  logic                tick;
  logic                advance;

  sec_tick_sync u_sync (
    .clk_20   (clk_20),
    .rst      (rst),
    .clk_1Hz  (clk_1Hz),
    .sec_tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    advance  = 1'b0;
    if (tick) begin
      if (remain_q > REMAIN_W'(1)) begin
        remain_d = remain_q - REMAIN_W'(1);
      end else begin
`ifdef SIDE_SENSOR_EN
        // main green is extended at remain==1 until a side car is waiting
        advance = (state_q != MAIN_G) || side_car;
`else
        advance = 1'b1;
`endif
      end
    end
    if (advance) begin
      state_d  = next_phase(state_q);
      remain_d = dur_of(next_phase(state_q));
    end
  end

  always_ff @(posedge clk_20) begin
    if (rst) begin
      state_q  <= MAIN_G;
      remain_q <= REMAIN_W'(T_MAIN_GREEN);
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    main_light = LT_RED;
    side_light = LT_RED;
    case (state_q)
      MAIN_G:  main_light = LT_GRN;
      MAIN_Y:  main_light = LT_YEL;
      SIDE_G:  side_light = LT_GRN;
      SIDE_Y:  side_light = LT_YEL;
      default: ;
    endcase
  end

  assign remain   = remain_q;
  assign sec_tick = tick;

endmodule
